// File: rtl/priority_encoder_4x2_hs_if.sv
// Request/grant bundle for the 4-line priority encoder with valid/ready code output.
// The slave modport is the encoder's view; the master modport drives requests and consumes codes.
interface priority_encoder_4x2_hs_if;
    logic [0:3] D;        // active-low request lines, D[i] low = request i
    logic       enable;   // active-low capture enable
    logic       ready;
    logic       A;
    logic       B;
    logic       valid;
    logic [0:3] pending;

    modport slave (
        input  D,
        input  enable,
        input  ready,
        output A,
        output B,
        output valid,
        output pending
    );

    modport master (
        output D,
        output enable,
        output ready,
        input  A,
        input  B,
        input  valid,
        input  pending
    );
endinterface

// File: rtl/priority_encoder_4x2_hs.sv
// Sticky 4-line request capture with a registered 2-bit grant code under a valid/ready handshake.
// Define ROUND_ROBIN_EN for rotating priority; otherwise line 3 always has the highest priority.
module priority_encoder_4x2_hs (
    input  logic                            clk,
    input  logic                            rst,
    priority_encoder_4x2_hs_if.slave        bus
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [0:3] pending_q, pending_d;
    logic       a_q, a_d;
    logic       b_q, b_d;

    logic [0:3] capture_mask;
    logic [0:3] clear_mask;
    logic [1:0] grant_idx;
    logic [1:0] sel_idx;
    logic       handshake;

    assign grant_idx = {a_q, b_q};
    // ready is only meaningful while a code is being presented
    assign handshake = (state_q == ST_PRESENT) && bus.ready;

    for (genvar gi = 0; gi < 4; gi++) begin : g_line
        assign capture_mask[gi] = ~bus.enable & ~bus.D[gi];
        assign clear_mask[gi]   = handshake & (grant_idx == 2'(gi));
    end

`ifdef ROUND_ROBIN_EN
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] rr_cand;

    // Walk from the farthest candidate to the nearest so the line just after last_grant wins.
    always_comb begin
        sel_idx = 2'd0;
        rr_cand = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            rr_cand = last_grant_q + 2'd1 + 2'(k);
            if (pending_q[rr_cand]) begin
                sel_idx = rr_cand;
            end
        end
    end

    always_comb begin
        last_grant_d = handshake ? grant_idx : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 2'd3;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        sel_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending_q[i]) begin
                sel_idx = 2'(i);
            end
        end
    end
`endif

    always_comb begin
        // Capture is OR-ed in after the clear so a same-edge re-request keeps its bit.
        pending_d = (pending_q & ~clear_mask) | capture_mask;
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    {a_d, b_d} = sel_idx;
                    state_d    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (bus.ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'b0000;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.valid   = (state_q == ST_PRESENT);
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_priority_encoder_4x2_hs.sv
// Bench for priority_encoder_4x2_hs: directed scenarios with literal expectations, then
// random traffic checked every cycle against a set-of-lines / current-grant model.
module tb_priority_encoder_4x2_hs;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    priority_encoder_4x2_hs_if bus ();

    priority_encoder_4x2_hs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: set of pending lines, the line currently granted (-1 = none), last line served.
    bit [0:3] m_pend;
    bit [0:3] m_next;
    int       m_grant;
    int       m_last;
    logic [0:3] exp_pend;
    logic       exp_valid;

    function automatic int pick(bit [0:3] p, int last);
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (p[(last + k) % 4]) return (last + k) % 4;
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (p[k]) return k;
        end
`endif
        return -1;
    endfunction

    initial begin
        m_pend  = '0;
        m_grant = -1;
        m_last  = 3;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pend  = '0;
            m_grant = -1;
            m_last  = 3;
        end else begin
            m_next = m_pend;
            for (int i = 0; i < 4; i++) begin
                if (!bus.enable && !bus.D[i]) m_next[i] = 1'b1;
            end
            if (m_grant >= 0) begin
                if (bus.ready) begin
                    m_next[m_grant] = !bus.enable && !bus.D[m_grant];
                    m_last          = m_grant;
                    m_grant         = -1;
                end
            end else if (m_pend != '0) begin
                m_grant = pick(m_pend, m_last);
            end
            m_pend = m_next;
        end
    end

    always @(negedge clk) begin
        exp_valid = (m_grant >= 0);
        exp_pend  = m_pend;
        n_tests++;
        if (bus.valid !== exp_valid || bus.pending !== exp_pend ||
            (exp_valid && ({bus.A, bus.B} !== 2'(m_grant)))) begin
            n_fail++;
            $display("FAIL model_cmp @%0t: got valid=%b code=%b%b pending=%b, expected valid=%b code=%0d pending=%b",
                     $time, bus.valid, bus.A, bus.B, bus.pending, exp_valid, m_grant, exp_pend);
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.D      = 4'b1111;
        bus.enable = 1'b1;
    endtask

    int got_order[4];
    int n_got;
    int exp_order[4];

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.D      = 4'b1111;
        bus.enable = 1'b1;
        bus.ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Quiet inputs: nothing should ever appear.
        repeat (3) begin
            @(negedge clk);
            chk("quiet_valid", {3'b0, bus.valid}, 4'b0000);
            chk("quiet_pending", bus.pending, 4'b0000);
            chk("quiet_code", {2'b0, bus.A, bus.B}, 4'b0000);
        end

        // Single request on line 1 with ready already high.
        bus.D = 4'b1011; bus.enable = 1'b0; bus.ready = 1'b1;
        @(negedge clk);
        chk("single_pending", bus.pending, 4'b0100);
        chk("single_no_valid_yet", {3'b0, bus.valid}, 4'b0000);
        idle_inputs();
        @(negedge clk);
        chk("single_valid", {3'b0, bus.valid}, 4'b0001);
        chk("single_code", {2'b0, bus.A, bus.B}, 4'b0001);
        @(negedge clk);
        chk("single_after_hs_valid", {3'b0, bus.valid}, 4'b0000);
        chk("single_after_hs_pending", bus.pending, 4'b0000);

        // Lines 0 and 3, consumer stalls; line 3 is held, then line 0 after one bubble.
        bus.D = 4'b0110; bus.enable = 1'b0; bus.ready = 1'b0;
        @(negedge clk);
        chk("pair_pending", bus.pending, 4'b1001);
        idle_inputs();
        repeat (6) begin
            @(negedge clk);
            chk("stall_valid", {3'b0, bus.valid}, 4'b0001);
            chk("stall_code", {2'b0, bus.A, bus.B}, 4'b0011);
        end
        bus.ready = 1'b1;
        @(negedge clk);
        chk("bubble_valid", {3'b0, bus.valid}, 4'b0000);
        chk("bubble_pending", bus.pending, 4'b1000);
        @(negedge clk);
        chk("second_valid", {3'b0, bus.valid}, 4'b0001);
        chk("second_code", {2'b0, bus.A, bus.B}, 4'b0000);
        @(negedge clk);
        chk("pair_drained", bus.pending, 4'b0000);

        // Re-request on the granted line at the handshake edge beats the clear.
        bus.ready = 1'b0; bus.D = 4'b1011; bus.enable = 1'b0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("rereq_code", {2'b0, bus.A, bus.B}, 4'b0001);
        bus.D = 4'b1011; bus.enable = 1'b0; bus.ready = 1'b1;
        @(negedge clk);
        chk("rereq_kept", bus.pending, 4'b0100);
        chk("rereq_bubble", {3'b0, bus.valid}, 4'b0000);
        idle_inputs();
        @(negedge clk);
        chk("rereq_regrant_valid", {3'b0, bus.valid}, 4'b0001);
        chk("rereq_regrant_code", {2'b0, bus.A, bus.B}, 4'b0001);
        @(negedge clk);
        bus.ready = 1'b0;

        // Reset while presenting with every line pending.
        bus.D = 4'b0000; bus.enable = 1'b0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("full_pending", bus.pending, 4'b1111);
        chk("full_valid", {3'b0, bus.valid}, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", {3'b0, bus.valid}, 4'b0000);
        chk("rst_pending", bus.pending, 4'b0000);
        chk("rst_code", {2'b0, bus.A, bus.B}, 4'b0000);

        // Grant order with all four lines requested at once.
`ifdef ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3};
`else
        exp_order = '{3, 2, 1, 0};
`endif
        bus.D = 4'b0000; bus.enable = 1'b0; bus.ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_got = 0;
        for (int c = 0; c < 40 && n_got < 4; c++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                got_order[n_got] = int'({bus.A, bus.B});
                n_got++;
            end
        end
        chk("order_count", 4'(n_got), 4'd4);
        for (int j = 0; j < n_got; j++) begin
            chk($sformatf("order_%0d", j), 4'(got_order[j]), 4'(exp_order[j]));
        end
        bus.ready = 1'b0;

        // Random traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.D      = 4'($urandom);
            bus.enable = ($urandom_range(0, 2) != 0);
            bus.ready  = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
